// File: rtl/alu_share_scheduler_if.sv
// Bundle between the ALU share scheduler, its two requesters, the shared SIMD ALU
// and the result consumer. The master modport is the scheduler's view.
interface alu_share_scheduler_if;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [1:0][3:0]   req_alumode;
  logic [1:0][8:0]   req_opmode;
  logic [1:0][1:0]   req_use_simd;
  logic [1:0][47:0]  req_w;
  logic [1:0][47:0]  req_x;
  logic [1:0][47:0]  req_y;
  logic [1:0][47:0]  req_z;
  logic [1:0]        req_cin;
  logic [1:0]        req_chain;

  logic [3:0]        ALUMODE;
  logic [8:0]        OPMODE;
  logic [1:0]        USE_SIMD;
  logic [47:0]       W;
  logic [47:0]       X;
  logic [47:0]       Y;
  logic [47:0]       Z;
  logic              CIN;
  logic [47:0]       S;
  logic              COUT;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [47:0]       rsp_s;
  logic              rsp_cout;

  modport master (
    input  req_valid, req_alumode, req_opmode, req_use_simd,
           req_w, req_x, req_y, req_z, req_cin, req_chain,
           S, COUT, rsp_ready,
    output req_ready, ALUMODE, OPMODE, USE_SIMD, W, X, Y, Z, CIN,
           rsp_valid, rsp_id, rsp_s, rsp_cout
  );

  modport slave (
    output req_valid, req_alumode, req_opmode, req_use_simd,
           req_w, req_x, req_y, req_z, req_cin, req_chain,
           S, COUT, rsp_ready,
    input  req_ready, ALUMODE, OPMODE, USE_SIMD, W, X, Y, Z, CIN,
           rsp_valid, rsp_id, rsp_s, rsp_cout
  );
endinterface

// File: rtl/alu_share_scheduler.sv
// Two-requester round-robin scheduler for a shared SIMD ALU: issue stage drives the ALU,
// response stage captures S/COUT. Optional carry chaining via ALU_SCHED_CARRY_CHAIN_EN.
module alu_share_scheduler (
  input  logic                  CLK,
  input  logic                  RST,
  alu_share_scheduler_if.master bus
);
  localparam int unsigned NREQ = 2;

  logic            v1;
  logic            v2;
  logic            id1;
  logic            last_gnt;
  logic            advance_c;
  logic [NREQ-1:0] grant_c;
  logic            gid_c;
  logic            cin_sel_c;

  assign advance_c     = !(v2 && !bus.rsp_ready);
  assign bus.rsp_valid = v2;
  assign bus.req_ready = grant_c;
  assign gid_c         = grant_c[1];

  // Round-robin grant; last_gnt names the requester that lost priority.
  always_comb begin
    grant_c = '0;
    if (advance_c && !RST) begin
      case (bus.req_valid)
        2'b01:   grant_c = 2'b01;
        2'b10:   grant_c = 2'b10;
        2'b11:   grant_c = last_gnt ? 2'b01 : 2'b10;
        default: grant_c = 2'b00;
      endcase
    end
  end

`ifdef ALU_SCHED_CARRY_CHAIN_EN
  logic [NREQ-1:0] saved_cout;

  // A chained op takes the carry of its own previous op, forwarded if still in issue.
  always_comb begin
    cin_sel_c = bus.req_cin[gid_c];
    if (bus.req_chain[gid_c]) begin
      cin_sel_c = (v1 && (id1 == gid_c)) ? bus.COUT : saved_cout[gid_c];
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      saved_cout <= '0;
    end else if (advance_c && v1) begin
      saved_cout[id1] <= bus.COUT;
    end
  end
`else
  logic unused_chain;

  assign unused_chain = ^bus.req_chain;

  always_comb begin
    cin_sel_c = bus.req_cin[gid_c];
  end
`endif

  // Issue and response stages advance together; backpressure freezes both.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      v1           <= 1'b0;
      v2           <= 1'b0;
      id1          <= 1'b0;
      last_gnt     <= 1'b1;
      bus.ALUMODE  <= '0;
      bus.OPMODE   <= '0;
      bus.USE_SIMD <= '0;
      bus.W        <= '0;
      bus.X        <= '0;
      bus.Y        <= '0;
      bus.Z        <= '0;
      bus.CIN      <= 1'b0;
      bus.rsp_s    <= '0;
      bus.rsp_cout <= 1'b0;
      bus.rsp_id   <= 1'b0;
    end else if (advance_c) begin
      if (|grant_c) begin
        bus.ALUMODE  <= bus.req_alumode[gid_c];
        bus.OPMODE   <= bus.req_opmode[gid_c];
        bus.USE_SIMD <= bus.req_use_simd[gid_c];
        bus.W        <= bus.req_w[gid_c];
        bus.X        <= bus.req_x[gid_c];
        bus.Y        <= bus.req_y[gid_c];
        bus.Z        <= bus.req_z[gid_c];
        bus.CIN      <= cin_sel_c;
        v1           <= 1'b1;
        id1          <= gid_c;
        last_gnt     <= gid_c;
      end else begin
        v1           <= 1'b0;
      end
      v2           <= v1;
      bus.rsp_s    <= bus.S;
      bus.rsp_cout <= bus.COUT;
      bus.rsp_id   <= id1;
    end
  end
endmodule

// File: tb/tb_alu_share_scheduler.sv
// Directed bench for alu_share_scheduler with a behavioural adder standing in for the ALU.
module tb_alu_share_scheduler;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   checks = 0;
  int   failures = 0;
  logic [48:0] alu_sum;

  alu_share_scheduler_if bus ();

  alu_share_scheduler dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  // ALUMODE=0000 model: S = W + X + Y + Z + CIN, COUT = carry out of bit 47.
  assign alu_sum  = 49'(bus.W) + 49'(bus.X) + 49'(bus.Y) + 49'(bus.Z) + 49'(bus.CIN);
  assign bus.S    = alu_sum[47:0];
  assign bus.COUT = alu_sum[48];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int r, input logic [47:0] x, input logic [47:0] y,
                         input logic cin, input logic chain);
    bus.req_x[r]     = x;
    bus.req_y[r]     = y;
    bus.req_cin[r]   = cin;
    bus.req_chain[r] = chain;
  endtask

  initial begin
    bus.req_valid    = 2'b00;
    bus.req_alumode  = '0;
    bus.req_opmode   = '0;
    bus.req_use_simd = '0;
    bus.req_w        = '0;
    bus.req_x        = '0;
    bus.req_y        = '0;
    bus.req_z        = '0;
    bus.req_cin      = '0;
    bus.req_chain    = '0;
    bus.rsp_ready    = 1'b1;

    // Reset state, with requests present to prove req_ready is gated.
    repeat (2) @(negedge CLK);
    bus.req_valid = 2'b11;
    #1;
    check("rst_req_ready", 64'(bus.req_ready), 64'h0);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'h0);
    check("rst_alumode", 64'(bus.ALUMODE), 64'h0);
    check("rst_x", 64'(bus.X), 64'h0);
    check("rst_cin", 64'(bus.CIN), 64'h0);
    check("rst_rsp_s", 64'(bus.rsp_s), 64'h0);
    bus.req_valid = 2'b00;
    @(negedge CLK);
    RST = 1'b0;

    // Single op from requester 0: 5 + 3.
    @(negedge CLK);
    set_req(0, 48'd5, 48'd3, 1'b0, 1'b0);
    bus.req_valid = 2'b01;
    #1;
    check("single_ready", 64'(bus.req_ready), 64'h1);
    @(negedge CLK);
    bus.req_valid = 2'b00;
    #1;
    check("single_ready_drop", 64'(bus.req_ready), 64'h0);
    check("single_x_drive", 64'(bus.X), 64'd5);
    check("single_no_rsp_yet", 64'(bus.rsp_valid), 64'h0);
    @(negedge CLK);
    check("single_rsp_valid", 64'(bus.rsp_valid), 64'h1);
    check("single_rsp_id", 64'(bus.rsp_id), 64'h0);
    check("single_rsp_s", 64'(bus.rsp_s), 64'd8);

    // Single op from requester 1 (7 + 9) so requester 0 wins the next contention.
    set_req(1, 48'd7, 48'd9, 1'b0, 1'b0);
    bus.req_valid = 2'b10;
    #1;
    check("r1_ready", 64'(bus.req_ready), 64'h2);
    @(negedge CLK);
    bus.req_valid = 2'b00;
    @(negedge CLK);
    check("r1_rsp_id", 64'(bus.rsp_id), 64'h1);
    check("r1_rsp_s", 64'(bus.rsp_s), 64'd16);

    // Contention for 4 cycles: grants alternate, one response per cycle.
    set_req(0, 48'd10, 48'd20, 1'b0, 1'b0);
    set_req(1, 48'd1000, 48'd2000, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      if (k >= 2) begin
        check("rr_rsp_valid", 64'(bus.rsp_valid), 64'h1);
        check("rr_rsp_id", 64'(bus.rsp_id), 64'(k % 2));
        check("rr_rsp_s", 64'(bus.rsp_s), (k % 2 == 0) ? 64'd30 : 64'd3000);
      end
      bus.req_valid = (k < 4) ? 2'b11 : 2'b00;
      #1;
      if (k < 4) check("rr_grant", 64'(bus.req_ready), (k % 2 == 0) ? 64'h1 : 64'h2);
      @(negedge CLK);
    end
    check("rr_drain", 64'(bus.rsp_valid), 64'h0);

    // Backpressure: response held 3 cycles, no grants, then handshake plus new grant.
    set_req(0, 48'd40, 48'd2, 1'b0, 1'b0);
    bus.req_valid = 2'b01;
    #1;
    check("bp_ready0", 64'(bus.req_ready), 64'h1);
    @(negedge CLK);
    bus.req_valid = 2'b00;
    @(negedge CLK);
    check("bp_rsp_s", 64'(bus.rsp_s), 64'd42);
    set_req(1, 48'd50, 48'd5, 1'b0, 1'b0);
    bus.rsp_ready = 1'b0;
    bus.req_valid = 2'b10;
    #1;
    check("bp_stall_ready", 64'(bus.req_ready), 64'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      check("bp_hold_valid", 64'(bus.rsp_valid), 64'h1);
      check("bp_hold_s", 64'(bus.rsp_s), 64'd42);
      check("bp_hold_ready", 64'(bus.req_ready), 64'h0);
      check("bp_hold_x", 64'(bus.X), 64'd40);
    end
    bus.rsp_ready = 1'b1;
    #1;
    check("bp_resume_ready", 64'(bus.req_ready), 64'h2);
    @(negedge CLK);
    bus.req_valid = 2'b00;
    check("bp_consumed", 64'(bus.rsp_valid), 64'h0);
    @(negedge CLK);
    check("bp_next_valid", 64'(bus.rsp_valid), 64'h1);
    check("bp_next_id", 64'(bus.rsp_id), 64'h1);
    check("bp_next_s", 64'(bus.rsp_s), 64'd55);

    // Carry chain: all-ones + 1, then 0 + 0 chained back-to-back on requester 0.
    set_req(0, 48'hFFFF_FFFF_FFFF, 48'd1, 1'b0, 1'b0);
    bus.req_valid = 2'b01;
    #1;
    check("cc_ready_a", 64'(bus.req_ready), 64'h1);
    @(negedge CLK);
    set_req(0, 48'd0, 48'd0, 1'b0, 1'b1);
    #1;
    check("cc_ready_b", 64'(bus.req_ready), 64'h1);
    @(negedge CLK);
    bus.req_valid = 2'b00;
    bus.req_chain = 2'b00;
    check("cc_first_cout", 64'(bus.rsp_cout), 64'h1);
    check("cc_first_s", 64'(bus.rsp_s), 64'h0);
`ifdef ALU_SCHED_CARRY_CHAIN_EN
    check("cc_cin_drive", 64'(bus.CIN), 64'h1);
    @(negedge CLK);
    check("cc_second_s", 64'(bus.rsp_s), 64'h1);
`else
    check("cc_cin_drive", 64'(bus.CIN), 64'h0);
    @(negedge CLK);
    check("cc_second_s", 64'(bus.rsp_s), 64'h0);
`endif
    check("cc_second_cout", 64'(bus.rsp_cout), 64'h0);

    // Reset with both stages full: discard in-flight ops, pointer back to requester 0.
    @(negedge CLK);
    set_req(0, 48'd1, 48'd1, 1'b0, 1'b0);
    bus.req_valid = 2'b01;
    @(negedge CLK);
    set_req(0, 48'd2, 48'd2, 1'b0, 1'b0);
    @(negedge CLK);
    bus.req_valid = 2'b00;
    check("mid_pre_valid", 64'(bus.rsp_valid), 64'h1);
    RST = 1'b1;
    #1;
    check("mid_rst_valid", 64'(bus.rsp_valid), 64'h0);
    check("mid_rst_x", 64'(bus.X), 64'h0);
    @(negedge CLK);
    RST = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK);
      check("mid_no_stale", 64'(bus.rsp_valid), 64'h0);
    end
    set_req(0, 48'd11, 48'd22, 1'b0, 1'b0);
    set_req(1, 48'd33, 48'd44, 1'b0, 1'b0);
    bus.req_valid = 2'b11;
    #1;
    check("mid_first_grant", 64'(bus.req_ready), 64'h1);
    @(negedge CLK);
    bus.req_valid = 2'b00;
    @(negedge CLK);
    check("mid_rsp_id", 64'(bus.rsp_id), 64'h0);
    check("mid_rsp_s", 64'(bus.rsp_s), 64'd33);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
